// File: rtl/curve448_pkg.sv
// Shared field types and constants for the Curve448 arithmetic units.
// Holds the prime, operation codes and add/sub FSM states.
package curve448_pkg;

  typedef logic [447:0] fe_t;

  localparam fe_t P448 = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  typedef enum logic {
    OP_ADD,
    OP_SUB
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    ARITH,
    CORR,
    DONE
  } addsub_state_t;

endpackage

// File: rtl/mod_addsub_seq_limb.sv
// One limb of a ripple add/sub: a + b or a + ~b, plus carry-in.
// Subtraction relies on the caller injecting cin=1 on the lowest limb.
module limb_addsub #(
  parameter int LIMB_W = 112
) (
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              sub,
  input  logic              cin,
  output logic [LIMB_W-1:0] s,
  output logic              cout
);

  logic [LIMB_W:0]   r;
  logic [LIMB_W-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign r     = {1'b0, a} + {1'b0, b_eff}
               + {{LIMB_W{1'b0}}, cin};
  assign s     = r[LIMB_W-1:0];
  assign cout  = r[LIMB_W];

endmodule

// File: rtl/mod_addsub_seq.sv
// Limb-serial modular add/sub: raw pass (S = X +/- Y), then a
// correction pass (T = S -/+ p), then pick S or T into the result.
module mod_addsub_seq
  import curve448_pkg::*;
#(
  parameter int               WIDTH   = 448,
  parameter int               LIMB_W  = 112,
  parameter logic [WIDTH-1:0] MODULUS = WIDTH'(P448)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] iX,
  input  logic [WIDTH-1:0] iY,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] oO
);

  localparam int NLIMBS = WIDTH / LIMB_W;
  localparam int CW     = $clog2(NLIMBS + 1);
  localparam logic [CW-1:0] LAST = CW'(NLIMBS - 1);

  if (WIDTH % LIMB_W != 0) begin : g_bad_limb
    $error("WIDTH must be a multiple of LIMB_W");
  end
  if (MODULUS[0] == 1'b0) begin : g_bad_mod
    $error("MODULUS must be odd");
  end

  addsub_state_t    state_q, state_d;
  op_t              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             c1_q, c1_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] s_q, s_d, t_q, t_d;
  logic [WIDTH-1:0] oo_q, oo_d;
  logic [WIDTH-1:0] t_full;

  logic [LIMB_W-1:0] a_l, b_l, sum_l;
  logic              sub_l, cin_l, cout_l;
  logic              is_last, take_t;

  limb_addsub #(.LIMB_W(LIMB_W)) u_limb (
    .a   (a_l),
    .b   (b_l),
    .sub (sub_l),
    .cin (cin_l),
    .s   (sum_l),
    .cout(cout_l)
  );

  assign is_last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    c1_d    = c1_q;
    x_d     = x_q;
    y_d     = y_q;
    s_d     = s_q;
    t_d     = t_q;
    oo_d    = oo_q;
    a_l     = '0;
    b_l     = '0;
    sub_l   = 1'b0;
    cin_l   = 1'b0;
    take_t  = 1'b0;
    t_full  = t_q;
    t_full[LIMB_W*int'(cnt_q) +: LIMB_W] = sum_l;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARITH;
          x_d     = iX;
          y_d     = iY;
          op_d    = op_t'(mode);
          cnt_d   = '0;
          c_d     = 1'b0;
        end
      end
      ARITH: begin
        a_l   = x_q[LIMB_W*int'(cnt_q) +: LIMB_W];
        b_l   = y_q[LIMB_W*int'(cnt_q) +: LIMB_W];
        sub_l = (op_q == OP_SUB);
        cin_l = (cnt_q == '0) ? sub_l : c_q;
        c_d   = cout_l;
        cnt_d = cnt_q + CW'(1);
        s_d[LIMB_W*int'(cnt_q) +: LIMB_W] = sum_l;
        if (is_last) begin
          // c1 means "overflowed" for add, "went negative" for sub
          c1_d    = sub_l ? ~cout_l : cout_l;
          cnt_d   = '0;
          state_d = CORR;
        end
      end
      CORR: begin
        a_l   = s_q[LIMB_W*int'(cnt_q) +: LIMB_W];
        b_l   = MODULUS[LIMB_W*int'(cnt_q) +: LIMB_W];
        sub_l = (op_q == OP_ADD);
        cin_l = (cnt_q == '0) ? sub_l : c_q;
        c_d   = cout_l;
        cnt_d = cnt_q + CW'(1);
        t_d   = t_full;
        if (is_last) begin
          take_t  = (op_q == OP_ADD) ? (c1_q | cout_l) : c1_q;
          oo_d    = take_t ? t_full : s_q;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      c1_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      t_q     <= '0;
      oo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      c1_q    <= c1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      s_q     <= s_d;
      t_q     <= t_d;
      oo_q    <= oo_d;
    end
  end

  assign busy = (state_q == ARITH) || (state_q == CORR);
  assign done = (state_q == DONE);
  assign oO   = oo_q;

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Bench for mod_addsub_seq: Curve448 config and a 56-bit-limb,
// 224-bit-prime config, checked against modular arithmetic.
module tb_mod_addsub_seq;
  import curve448_pkg::*;

  localparam logic [447:0] P224 =
    (448'd1 << 224) - (448'd1 << 96) + 448'd1;

  logic clk;
  logic reset_s [2];
  logic start_s [2];
  logic mode_s  [2];
  logic [447:0] ix_s [2];
  logic [447:0] iy_s [2];
  logic busy_s  [2];
  logic done_s  [2];
  logic [447:0] oo_s [2];

  logic [447:0] pm [2];
  int nl [2];

  int n_chk = 0;
  int n_err = 0;

  mod_addsub_seq u_dut0 (
    .clk  (clk),
    .reset(reset_s[0]),
    .start(start_s[0]),
    .mode (mode_s[0]),
    .iX   (ix_s[0]),
    .iY   (iy_s[0]),
    .busy (busy_s[0]),
    .done (done_s[0]),
    .oO   (oo_s[0])
  );

  mod_addsub_seq #(
    .WIDTH  (448),
    .LIMB_W (56),
    .MODULUS(P224)
  ) u_dut1 (
    .clk  (clk),
    .reset(reset_s[1]),
    .start(start_s[1]),
    .mode (mode_s[1]),
    .iX   (ix_s[1]),
    .iY   (iy_s[1]),
    .busy (busy_s[1]),
    .done (done_s[1]),
    .oO   (oo_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [447:0] got,
                     input logic [447:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [447:0] ref_op(
    input bit m, input logic [447:0] x,
    input logic [447:0] y, input logic [447:0] p);
    logic [449:0] w;
    if (m) w = {2'b0, x} + {2'b0, p} - {2'b0, y};
    else   w = {2'b0, x} + {2'b0, y};
    w = w % {2'b0, p};
    return w[447:0];
  endfunction

  function automatic logic [447:0] rnd_fe(input logic [447:0] p);
    logic [447:0] v;
    for (int i = 0; i < 14; i++) v[32*i +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0: return '0;
      1: return p - 448'd1;
      default: return v % p;
    endcase
  endfunction

  task automatic issue(input int u, input bit m,
                       input logic [447:0] x,
                       input logic [447:0] y);
    @(negedge clk);
    start_s[u] = 1'b1;
    mode_s[u]  = m;
    ix_s[u]    = x;
    iy_s[u]    = y;
    @(negedge clk);
    start_s[u] = 1'b0;
    mode_s[u]  = ~m;
    ix_s[u]    = ~x;
    iy_s[u]    = ~y;
  endtask

  task automatic wait_done(input int u,
                           output logic [447:0] r,
                           output int lat,
                           output bit bz_ok);
    lat   = -1;
    bz_ok = 1'b1;
    r     = '0;
    for (int n = 1; n <= 80; n++) begin
      if (done_s[u]) begin
        lat = n;
        r   = oo_s[u];
        if (busy_s[u]) bz_ok = 1'b0;
        break;
      end
      if (!busy_s[u]) bz_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_chk(input int u, input string tag,
                         input bit m,
                         input logic [447:0] x,
                         input logic [447:0] y,
                         input bit full);
    logic [447:0] r;
    int lat;
    bit bz;
    issue(u, m, x, y);
    wait_done(u, r, lat, bz);
    chk($sformatf("u%0d %s", u, tag), r, ref_op(m, x, y, pm[u]));
    if (full) begin
      chk($sformatf("u%0d %s lat", u, tag), 448'(lat),
          448'(2 * nl[u] + 1));
      chk($sformatf("u%0d %s busy", u, tag), 448'(bz), 448'd1);
    end
  endtask

  initial begin
    logic [447:0] r, p;
    int lat, pulses;
    bit bz;
    pm[0] = P448;
    pm[1] = P224;
    nl[0] = 4;
    nl[1] = 8;
    for (int u = 0; u < 2; u++) begin
      reset_s[u] = 1'b1;
      start_s[u] = 1'b0;
      mode_s[u]  = 1'b0;
      ix_s[u]    = '0;
      iy_s[u]    = '0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d rst busy", u), 448'(busy_s[u]), '0);
      chk($sformatf("u%0d rst done", u), 448'(done_s[u]), '0);
      chk($sformatf("u%0d rst oO", u), oo_s[u], '0);
      reset_s[u] = 1'b0;
    end

    for (int u = 0; u < 2; u++) begin
      p = pm[u];
      run_chk(u, "add 1+2", 1'b0, 448'd1, 448'd2, 1'b1);
      chk($sformatf("u%0d add 1+2 val", u), oo_s[u], 448'd3);
      run_chk(u, "add p-1+1", 1'b0, p - 1, 448'd1, 1'b1);
      run_chk(u, "add p-1+p-1", 1'b0, p - 1, p - 1, 1'b1);
      run_chk(u, "sub 5-3", 1'b1, 448'd5, 448'd3, 1'b1);
      run_chk(u, "sub 0-1", 1'b1, 448'd0, 448'd1, 1'b1);
      chk($sformatf("u%0d sub 0-1 val", u), oo_s[u], p - 1);
      run_chk(u, "sub 1-(p-1)", 1'b1, 448'd1, p - 1, 1'b1);
      chk($sformatf("u%0d sub 1-(p-1) val", u), oo_s[u], 448'd2);

      // extra starts while busy must be dropped
      issue(u, 1'b0, 448'd7, 448'd8);
      pulses = 0;
      r = '0;
      for (int n = 1; n <= 2 * nl[u] + 8; n++) begin
        if (done_s[u]) begin
          pulses++;
          r = oo_s[u];
        end
        start_s[u] = (n == 3 || n == 5);
        mode_s[u]  = 1'b1;
        ix_s[u]    = 448'd100;
        iy_s[u]    = 448'd1;
        @(negedge clk);
      end
      start_s[u] = 1'b0;
      chk($sformatf("u%0d busy-start pulses", u), 448'(pulses), 448'd1);
      chk($sformatf("u%0d busy-start val", u), r, 448'd15);

      // start raised on the done cycle, held into IDLE
      run_chk(u, "add 10+20", 1'b0, 448'd10, 448'd20, 1'b0);
      start_s[u] = 1'b1;
      mode_s[u]  = 1'b0;
      ix_s[u]    = 448'd2;
      iy_s[u]    = 448'd3;
      @(negedge clk);
      chk($sformatf("u%0d b2b idle", u), 448'(busy_s[u]), '0);
      @(negedge clk);
      start_s[u] = 1'b0;
      wait_done(u, r, lat, bz);
      chk($sformatf("u%0d b2b val", u), r, 448'd5);
      chk($sformatf("u%0d b2b lat", u), 448'(lat),
          448'(2 * nl[u] + 1));

      // reset in the middle of an operation
      issue(u, 1'b0, p - 1, p - 1);
      repeat (3) @(negedge clk);
      reset_s[u] = 1'b1;
      @(negedge clk);
      chk($sformatf("u%0d abort busy", u), 448'(busy_s[u]), '0);
      chk($sformatf("u%0d abort done", u), 448'(done_s[u]), '0);
      chk($sformatf("u%0d abort oO", u), oo_s[u], '0);
      reset_s[u] = 1'b0;
      pulses = 0;
      for (int n = 0; n < 2 * nl[u] + 4; n++) begin
        if (done_s[u]) pulses++;
        @(negedge clk);
      end
      chk($sformatf("u%0d abort no done", u), 448'(pulses), '0);
      run_chk(u, "add 2+2", 1'b0, 448'd2, 448'd2, 1'b1);
      chk($sformatf("u%0d add 2+2 val", u), oo_s[u], 448'd4);
    end

    for (int i = 0; i < 1500; i++)
      run_chk(0, "rnd", 1'($urandom), rnd_fe(pm[0]), rnd_fe(pm[0]),
              (i % 100) == 0);
    for (int i = 0; i < 600; i++)
      run_chk(1, "rnd", 1'($urandom), rnd_fe(pm[1]), rnd_fe(pm[1]),
              (i % 100) == 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
